// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MIPS core and the host/debug port, with read-return routing.
// Optional build macro DMEM_ARB_ROUND_ROBIN_EN replaces fixed core priority with round-robin contention.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CORE_RD,
        HOST_RD
    } rd_state_t;

    rd_state_t state;
    logic      host_wins;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Resets to "host last" so the core takes the first contention.
    logic last_host;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_host <= 1'b1;
        end else if (c_gnt) begin
            last_host <= 1'b0;
        end else if (h_gnt) begin
            last_host <= 1'b1;
        end
    end

    assign host_wins = ~last_host;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Counts consecutive denied host cycles; any grant or dropped request restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (h_req && !h_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign host_wins = (starve_cnt == STARVE_LIM);
`endif

    assign c_gnt = reset && c_req && !(h_req && host_wins);
    assign h_gnt = reset && h_req && (!c_req || host_wins);

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (h_gnt) begin
            m_en    = 1'b1;
            m_we    = h_we;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end
    end

    // Remembers who issued the read so next cycle's memory data goes to that port only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (c_gnt && !c_we) begin
            state <= CORE_RD;
        end else if (h_gnt && !h_we) begin
            state <= HOST_RD;
        end else begin
            state <= IDLE;
        end
    end

    assign c_rvalid = (state == CORE_RD);
    assign h_rvalid = (state == HOST_RD);
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign h_rdata  = h_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a read-return scoreboard.
// Define DMEM_ARB_ROUND_ROBIN_EN for both bench and RTL to exercise the round-robin build.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, h_req, h_we;
    logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
    logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [31:0] c_rdata, h_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;

    typedef struct {
        logic        is_host;
        logic [31:0] data;
    } rd_t;

    rd_t         sb[$];
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        rst_drive = 1'b0;
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency, driven only by the DUT's m_* bus.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr[7:2]] <= m_wdata;
            else      m_rdata <= mem[m_addr[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, compare 1ns later, update the model for accepted accesses.
    task automatic step(input string tag,
                        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                        input logic egc, input logic egh);
        rd_t         e;
        logic        ecv = 1'b0;
        logic        ehv = 1'b0;
        logic [31:0] ed  = 32'h0;
        @(negedge clk);
        reset = rst_drive;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            ecv = !e.is_host;
            ehv = e.is_host;
            ed  = e.data;
        end
        check({tag, ".c_rvalid"}, {31'h0, c_rvalid}, {31'h0, ecv});
        check({tag, ".h_rvalid"}, {31'h0, h_rvalid}, {31'h0, ehv});
        check({tag, ".c_rdata"}, c_rdata, ecv ? ed : 32'h0);
        check({tag, ".h_rdata"}, h_rdata, ehv ? ed : 32'h0);
        check({tag, ".c_gnt"}, {31'h0, c_gnt}, {31'h0, egc});
        check({tag, ".h_gnt"}, {31'h0, h_gnt}, {31'h0, egh});
        if (egc || egh) begin
            check({tag, ".m_en"}, {31'h0, m_en}, 32'h1);
            check({tag, ".m_we"}, {31'h0, m_we}, {31'h0, egc ? cw : hw});
            check({tag, ".m_addr"}, m_addr, egc ? ca : ha);
            check({tag, ".m_wdata"}, m_wdata, egc ? cd : hd);
            if (egc ? cw : hw) begin
                ref_mem[egc ? ca[7:2] : ha[7:2]] = egc ? cd : hd;
            end else begin
                e.is_host = egh;
                e.data    = ref_mem[egc ? ca[7:2] : ha[7:2]];
                sb.push_back(e);
            end
        end else begin
            check({tag, ".m_en"}, {31'h0, m_en}, 32'h0);
            check({tag, ".m_we"}, {31'h0, m_we}, 32'h0);
            check({tag, ".m_addr"}, m_addr, 32'h0);
            check({tag, ".m_wdata"}, m_wdata, 32'h0);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        h_req = 1'b0; h_we = 1'b0; h_addr = 32'h0; h_wdata = 32'h0;

        $display("[TB] reset with both requesting: no grants");
        step("por0", 1'b1, 1'b1, 32'h50, 32'h1, 1'b1, 1'b1, 32'h54, 32'h2, 1'b0, 1'b0);
        step("por1", 1'b1, 1'b0, 32'h50, 32'h1, 1'b1, 1'b0, 32'h54, 32'h2, 1'b0, 1'b0);
        rst_drive = 1'b1;
        idle("rel");

        $display("[TB] core writes and readback");
        step("cw50", 1'b1, 1'b1, 32'h50, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("cw54", 1'b1, 1'b1, 32'h54, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("cr54", 1'b1, 1'b0, 32'h54, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle("cr54_ret");

        $display("[TB] host preload, core read");
        step("hw10", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        step("cr10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle("cr10_ret");

        $display("[TB] back-to-back alternating reads");
        step("hw00", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00, 32'hA0A0A0A0, 1'b0, 1'b1);
        step("hw04", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h04, 32'hB4B4B4B4, 1'b0, 1'b1);
        step("hw08", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h08, 32'hC8C8C8C8, 1'b0, 1'b1);
        step("cr00", 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("hr04", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b1);
        step("cr08", 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle("b2b_ret");

`ifndef DMEM_ARB_ROUND_ROBIN_EN
        $display("[TB] starvation guard");
        step("hw20", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("starve%0d", i), 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
        end
        step("starve_win", 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
        step("core_back", 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle("starve_ret");

        $display("[TB] dropped host request clears the starvation count");
        for (int i = 0; i < 3; i++) begin
            step($sformatf("pre%0d", i), 1'b1, 1'b0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
        end
        step("hdrop", 1'b1, 1'b0, 32'h54, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("post%0d", i), 1'b1, 1'b0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
        end
        step("post_win", 1'b1, 1'b0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
        idle("post_ret");
`endif

        $display("[TB] reset with a core read in flight");
        step("rst_rd", 1'b1, 1'b0, 32'h54, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_drive = 1'b0;
        sb.delete();
        step("rst_a", 1'b1, 1'b0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0);
        step("rst_b", 1'b1, 1'b0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0);
        rst_drive = 1'b1;
        idle("rst_rel");

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        $display("[TB] round-robin contention");
        step("rr0", 1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0);
        step("rr1", 1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b1);
        step("rr2", 1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0);
        step("rr3", 1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b1);
        idle("rr_ret");
`else
        $display("[TB] contention after reset: core first");
        step("prio", 1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0);
        idle("prio_ret");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory between the MIPS core and a host/debug port. It sits between `top`'s core data bus and `dmem`, and issues at most one access per cycle. It grants under fixed core priority with a host starvation guard, then routes the one-cycle-latency read data back to whichever requester issued the read. The host port is used by benches and loaders to preload or inspect data memory while the core runs.

## Interface
- `AW`, 32, address width (byte address, passed through unchanged)
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive denied host-request cycles after which the host wins contention (range 1–15)

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; clears all state when 0
- `c_req` in 1: core access request
- `c_we` in 1: core write (1) / read (0)
- `c_addr` in AW: core address
- `c_wdata` in DW: core write data
- `c_gnt` out 1: core access accepted this cycle
- `c_rvalid` out 1: core read data valid
- `c_rdata` out DW: core read data
- `h_req`, `h_we`, `h_addr`, `h_wdata` in 1/1/AW/DW: host request, same meaning as core
- `h_gnt` out 1, `h_rvalid` out 1, `h_rdata` out DW: host grant and read return
- `m_en` out 1: memory access strobe
- `m_we` out 1: memory write enable
- `m_addr` out AW, `m_wdata` out DW: memory address and write data
- `m_rdata` in DW: memory read data, valid the cycle after a read strobe

## Operation
- An access is accepted in a cycle where `x_req && x_gnt`. Grants are combinational from requests and registered arbitration state. `m_en/m_we/m_addr/m_wdata` are driven from the granted requester in the same cycle.
- With no grant: `m_en=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`.
- Arbitration (default build):
  - Core alone: core granted. Host alone: host granted.
  - Both requesting: core granted unless `starve_cnt == STARVE_MAX`, in which case host granted.
- `starve_cnt` (4 bits):
  - Increments, saturating at STARVE_MAX, on each cycle with `h_req=1` and `h_gnt=0`.
  - Clears to 0 when host is granted or `h_req=0`.
- Read-return FSM, states IDLE, CORE_RD, HOST_RD. Next state is set by the access accepted this cycle: core read → CORE_RD, host read → HOST_RD, write or none → IDLE.
- In CORE_RD: `c_rvalid=1`, `c_rdata=m_rdata`. In HOST_RD: `h_rvalid=1`, `h_rdata=m_rdata`.
- Back-to-back reads are legal: a new read may be accepted in the same cycle the previous read returns.
- Requesters must hold `req` and payload stable until granted.

## Timing
- Reset values: FSM=IDLE, `starve_cnt=0`. All `gnt`, `rvalid`, and `m_*` outputs are 0; `c_rdata`/`h_rdata` are 0.
- While `reset=0`, grants are forced to 0 regardless of requests.
- Write latency: 0 cycles; memory is written at the end of the grant cycle.
- Read latency: 1 cycle; `x_rvalid` is asserted exactly in cycle N+1 for a read accepted in cycle N.
- `x_rdata` is 0 whenever `x_rvalid=0`.
- Reset asserted with a read in flight: the read return is dropped and no `rvalid` pulse follows.
- Requester deasserts `req` while denied: no access occurs; `starve_cnt` clears.
- Starvation bound: with continuous core requests, the host is granted no later than the (STARVE_MAX+1)-th cycle of its request.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - Contention is resolved round-robin: the requester not granted most recently wins. The last-winner flag resets to "host", so the core wins the first contention.
  - `starve_cnt` is removed.
- Not defined: fixed core priority with starvation guard, as above.
- Single-requester behaviour and read routing are identical in both builds.

## Test plan
- Core writes 32'h7 to 0x50, then 0x54, host idle: `c_gnt=1` in each request cycle; `m_we=1` with `m_addr`=0x50/0x54 and `m_wdata`=0x7; reading back 0x54 gives `c_rvalid=1`, `c_rdata`=0x7 one cycle later.
- Host preloads 0x10←32'hDEADBEEF, core then reads 0x10: core gets `c_rdata`=32'hDEADBEEF; `h_rvalid` stays 0 throughout.
- Core requests continuously while host reads 0x20, STARVE_MAX=4: `h_gnt` is 0 for 4 cycles and 1 on the 5th; `h_rvalid` follows one cycle later; core is granted again the next cycle.
- Alternating back-to-back reads (core 0x0, host 0x4, core 0x8): each `rvalid` lands on the correct port one cycle after its grant, with no cross-routing.
- `reset` pulled low the cycle after a core read grant: no `c_rvalid` pulse; all outputs are 0 until reset releases.
- With `DMEM_ARB_ROUND_ROBIN_EN`, both requesting continuously: grants alternate core, host, core, host starting from core.
